// File: rtl/operation5_pkg.sv
// Shared constants and types for the operation-5 shifter datapath.
package operation5_pkg;
    localparam int DATA_W  = 6;
    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/barrel_shift6.sv
// Combinational 6-bit logical barrel shifter, stages of 1, 2 and 4, zero fill.
module barrel_shift6
    import operation5_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        amt,
    input  logic              dir,
    output logic [DATA_W-1:0] result
);
    logic [DATA_W-1:0] s1, s2;

    // Amounts of 6 and 7 push every bit out through the zero fill.
    always_comb begin
        s1 = data;
        if (amt[0]) s1 = (dir == DIR_RIGHT) ? (data >> 1) : (data << 1);
        s2 = s1;
        if (amt[1]) s2 = (dir == DIR_RIGHT) ? (s1 >> 2) : (s1 << 2);
        result = s2;
        if (amt[2]) result = (dir == DIR_RIGHT) ? (s2 >> 4) : (s2 << 4);
    end
endmodule

// File: rtl/operation5_shifter.sv
// Registered 6-bit logical shifter; each result bit is presented as a 4-bit digit code.
module operation5_shifter
    import operation5_pkg::*;
#(
    parameter int DATA_W  = 6,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               direction,
    input  logic [DATA_W-1:0]  X,
    input  logic [2:0]         shamt,
    output logic [DIGIT_W-1:0] d1,
    output logic [DIGIT_W-1:0] d2,
    output logic [DIGIT_W-1:0] d3,
    output logic [DIGIT_W-1:0] d4,
    output logic [DIGIT_W-1:0] d5,
    output logic [DIGIT_W-1:0] d6
);
    logic [DATA_W-1:0]  r;
    logic [DIGIT_W-1:0] dig_q [DATA_W];

    barrel_shift6 u_shift (
        .data   (X),
        .amt    (shamt),
        .dir    (direction),
        .result (r)
    );

    // dig_q[i] holds the digit for result bit i; all digits load on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_W; i++) begin
            if (!rst_n) dig_q[i] <= '0;
            else        dig_q[i] <= {{(DIGIT_W-1){1'b0}}, r[i]};
        end
    end

    assign d1 = dig_q[5];
    assign d2 = dig_q[4];
    assign d3 = dig_q[3];
    assign d4 = dig_q[2];
    assign d5 = dig_q[1];
    assign d6 = dig_q[0];
endmodule

// File: tb/tb_operation5_shifter.sv
// Self-checking bench for operation5_shifter: directed table, random stream, mid-stream reset.
module tb_operation5_shifter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       direction;
    logic [5:0] X;
    logic [2:0] shamt;
    logic [3:0] d1, d2, d3, d4, d5, d6;

    int total = 0;
    int bad   = 0;

    operation5_shifter dut (
        .clk(clk), .rst_n(rst_n), .direction(direction), .X(X), .shamt(shamt),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       dir;
        logic [5:0] x;
        logic [2:0] sh;
        logic [5:0] exp_r;
    } vec_t;

    // Reference: each output bit i takes source bit i-sh (left) or i+sh (right), else 0.
    function automatic logic [5:0] ref_r(input logic dir, input logic [5:0] x, input int sh);
        logic [5:0] r;
        int src;
        for (int i = 0; i < 6; i++) begin
            src = dir ? i + sh : i - sh;
            r[i] = (src >= 0 && src < 6) ? x[src] : 1'b0;
        end
        return r;
    endfunction

    function automatic logic [23:0] to_digits(input logic [5:0] r);
        logic [23:0] d;
        for (int k = 1; k <= 6; k++) d[24-4*k +: 4] = {3'b000, r[6-k]};
        return d;
    endfunction

    task automatic check(input string name, input logic [23:0] exp_d);
        logic [23:0] got;
        got = {d1, d2, d3, d4, d5, d6};
        total++;
        if (got !== exp_d) begin
            bad++;
            $display("FAIL %s: got d1..d6=%h required %h", name, got, exp_d);
        end
    endtask

    // Drive on the falling edge, let the rising edge capture, sample 1ns later.
    task automatic step(input logic rn, input logic dir, input logic [5:0] x, input logic [2:0] sh);
        @(negedge clk);
        rst_n = rn; direction = dir; X = x; shamt = sh;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"left_sh2",    1'b0, 6'b110100, 3'd2, 6'b010000};
        vecs[1] = '{"right_sh2",   1'b1, 6'b110100, 3'd2, 6'b001101};
        vecs[2] = '{"left_sh0",    1'b0, 6'b101011, 3'd0, 6'b101011};
        vecs[3] = '{"right_sh0",   1'b1, 6'b101011, 3'd0, 6'b101011};
        vecs[4] = '{"right_sh5",   1'b1, 6'b100000, 3'd5, 6'b000001};
        vecs[5] = '{"left_sh6",    1'b0, 6'b111111, 3'd6, 6'b000000};
        vecs[6] = '{"right_sh6",   1'b1, 6'b111111, 3'd6, 6'b000000};
        vecs[7] = '{"left_sh7",    1'b0, 6'b111111, 3'd7, 6'b000000};
        vecs[8] = '{"right_sh7",   1'b1, 6'b111111, 3'd7, 6'b000000};
        vecs[9] = '{"left_sh5",    1'b0, 6'b000001, 3'd5, 6'b100000};

        rst_n = 1'b0; direction = 1'b0; X = 6'b111111; shamt = 3'd0;

        // Reset held two cycles with an all-ones operand.
        step(1'b0, 1'b0, 6'b111111, 3'd0);
        check("reset_c1", 24'h0);
        step(1'b0, 1'b0, 6'b111111, 3'd0);
        check("reset_c2", 24'h0);

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].dir, vecs[i].x, vecs[i].sh);
            check(vecs[i].name, to_digits(vecs[i].exp_r));
        end

        // Back-to-back random stream, new inputs every cycle.
        for (int n = 0; n < 40; n++) begin
            logic       dir;
            logic [5:0] x;
            logic [2:0] sh;
            dir = 1'($urandom); x = 6'($urandom); sh = 3'($urandom);
            step(1'b1, dir, x, sh);
            check("random", to_digits(ref_r(dir, x, int'(sh))));
        end

        // Mid-stream reset: one cycle low, then first post-reset result.
        for (int n = 0; n < 3; n++) begin
            logic       dir;
            logic [5:0] x;
            logic [2:0] sh;
            step(1'b1, 1'b0, 6'b111111, 3'd0);
            check("pre_reset", 24'h111111);
            step(1'b0, 1'b1, 6'b111111, 3'd0);
            check("mid_reset", 24'h0);
            dir = 1'($urandom); x = 6'($urandom_range(1, 63)); sh = 3'($urandom_range(0, 5));
            step(1'b1, dir, x, sh);
            check("post_reset", to_digits(ref_r(dir, x, int'(sh))));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operation5_shifter.md
# operation5_shifter

Registered 6-bit logical shifter with per-bit display-digit outputs, used as operation 5 of the mini-project ALU/display datapath. Each cycle it shifts operand `X` left or right by `shamt` with zero fill. It then presents the six result bits as six 4-bit digit codes, `d1` (MSB) through `d6` (LSB), ready for the downstream digit/seven-segment decoder.

## Interface
- Clock `clk`; reset `rst_n`, synchronous and active-low.
- Parameters:
- `DATA_W`, default 6: operand width. Fixed at 6; one digit output per bit.
- `DIGIT_W`, default 4: width of each digit output.
- Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `direction`, input, 1: 0 = shift left (toward MSB); 1 = shift right (toward LSB).
- `X`, input, 6: operand. `X[5]` is the MSB.
- `shamt`, input, 3: shift amount, 0–7.
- `d1`, output, 4: digit for result bit 5 (MSB).
- `d2`, output, 4: digit for result bit 4.
- `d3`, output, 4: digit for result bit 3.
- `d4`, output, 4: digit for result bit 2.
- `d5`, output, 4: digit for result bit 1.
- `d6`, output, 4: digit for result bit 0 (LSB).

## Operation
- The combinational result R is 6 bits wide:
  - Left: R = (X << shamt) truncated to 6 bits.
  - Right: R = X >> shamt.
  - Vacated positions are always filled with 0. No rotation and no sign extension.
- `shamt` = 0 passes X through unchanged.
- `shamt` ≥ 6 gives R = 000000 in either direction.
- Digit encoding: `dk` = {3'b000, R[6-k]}. Each digit is therefore 4'h0 or 4'h1; no other values are legal.
- Inputs are not latched. A new operation is evaluated every cycle from the current input values.

## Timing
- Latency is 1 cycle. Inputs sampled at rising edge N appear on `d1`..`d6` after edge N, and stay stable until edge N+1.
- All six digit outputs are registered and update together. Outputs never mix results from different cycles.
- Reset: when `rst_n` = 0 at a rising edge, all of `d1`..`d6` become 4'h0. Inputs are ignored on that edge.
- The first valid result follows the first edge with `rst_n` = 1.
- If reset is asserted mid-stream, the outputs clear on the next edge and the in-flight result is discarded.
- No handshake and no back-pressure; throughput is one result per cycle.
- Outputs must have no combinational path from the inputs.

## Structure
- Shared package `operation5_pkg`:
  - Constants `DATA_W` = 6 and `DIGIT_W` = 4.
  - Typedef `digit_t` (logic [3:0]).
  - Constants `DIR_LEFT` = 1'b0 and `DIR_RIGHT` = 1'b1.
- Sub-module `barrel_shift6`: purely combinational, three-stage logarithmic shifter (stages of 1, 2 and 4).
  - Ports: `data`, `amt`, `dir`, `result`.
  - Implements the ≥6 zero rule naturally through zero fill.
- The top level instantiates `barrel_shift6`, registers R, and expands R into the six digit registers.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with X = 6'b111111 -> all of `d1`..`d6` = 4'h0.
- Left shift: X = 6'b110100, `shamt` = 2, `direction` = 0 -> one cycle later `d1`..`d6` = 0,1,0,0,0,0.
- Right shift: X = 6'b110100, `shamt` = 2, `direction` = 1 -> `d1`..`d6` = 0,0,1,1,0,1.
- Boundaries:
  - `shamt` = 0, X = 6'b101011 -> 1,0,1,0,1,1 in both directions.
  - `shamt` = 5 right, X = 6'b100000 -> 0,0,0,0,0,1.
  - `shamt` = 6 and 7, X = 6'b111111, both directions -> all 4'h0.
- Back-to-back: change inputs every cycle for 8 cycles. Each output set matches the previous cycle's inputs, and all digits update on the same edge.
- Mid-stream reset: assert `rst_n` = 0 for one cycle during a random stream -> outputs = 0 on that cycle. The result on the next cycle reflects the inputs sampled on the first edge with `rst_n` = 1.
